// File: rtl/gshare_predictor.sv
// gshare predictor: PC ^ global-history indexed saturating counters.
// Define PRED_STATS_EN to build resolved-branch and mispredict counters.
module gshare_predictor #(
    parameter int CNT_W = 2,
    parameter int IDX_W = 8,
    parameter int GHR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [31:0]      pd_pc,
    input  logic [31:0]      pd_inst,
    input  logic             pd_ena,
    output logic             pd_tk,
    output logic [31:0]      pd_off,
    output logic [GHR_W-1:0] pd_ghr,
    output logic             pd_busy,
    input  logic             fb_ena,
    input  logic [31:0]      fb_pc,
    input  logic             fb_tk,
    input  logic [GHR_W-1:0] fb_ghr,
    input  logic             fb_mis,
    output logic [31:0]      stat_br,
    output logic [31:0]      stat_mis
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] WNT = CNT_W'((2 ** (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [6:0] OP_BR = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6f;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [GHR_W-1:0] ghr;
    logic [CNT_W-1:0] tbl [DEPTH];

    logic             is_br;
    logic             is_jal;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] up_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] wr_val;
    logic             wr_en;
    logic             fb_acc;
    logic [GHR_W-1:0] ghr_nxt;
    logic             unused_bits;

    assign is_br   = pd_inst[6:0] == OP_BR;
    assign is_jal  = pd_inst[6:0] == OP_JAL;
    assign rd_idx  = pd_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign up_idx  = fb_pc[IDX_W+1:2] ^ IDX_W'(fb_ghr);
    assign pd_busy = state == INIT;
    assign pd_ghr  = ghr;
    assign fb_acc  = rdy & ~pd_busy & fb_ena;

    assign unused_bits = ^{pd_pc[31:IDX_W+2], pd_pc[1:0],
                           fb_pc[31:IDX_W+2], fb_pc[1:0]};

    always_comb begin
        pd_tk  = 1'b0;
        pd_off = 32'd4;
        unique case (1'b1)
            is_br: begin
                pd_tk  = ~pd_busy & tbl[rd_idx][CNT_W-1];
                pd_off = {{19{pd_inst[31]}}, pd_inst[31], pd_inst[7],
                          pd_inst[30:25], pd_inst[11:8], 1'b0};
            end
            is_jal: begin
                pd_tk  = 1'b1;
                pd_off = {{11{pd_inst[31]}}, pd_inst[31], pd_inst[19:12],
                          pd_inst[20], pd_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        up_cnt = tbl[up_idx];
        if (fb_tk) begin
            if (up_cnt != CMAX) up_cnt = up_cnt + CNT_W'(1);
        end else if (up_cnt != '0) begin
            up_cnt = up_cnt - CNT_W'(1);
        end
    end

    // The init sweep owns the write port until RUN.
    assign wr_en  = rst & ((pd_busy & rdy) | fb_acc);
    assign wr_idx = pd_busy ? ptr : up_idx;
    assign wr_val = pd_busy ? WNT : up_cnt;

    always_ff @(posedge clk) begin
        if (wr_en) tbl[wr_idx] <= wr_val;
    end

    always_comb begin
        ghr_nxt = ghr;
        if (fb_ena & fb_mis) begin
            ghr_nxt = (fb_ghr << 1) | GHR_W'(fb_tk);
        end else if (pd_ena & is_br) begin
            ghr_nxt = (ghr << 1) | GHR_W'(pd_tk);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            ptr   <= '0;
            ghr   <= '0;
        end else if (rdy) begin
            unique case (state)
                INIT: begin
                    ptr <= ptr + IDX_W'(1);
                    if (&ptr) state <= RUN;
                end
                RUN: ghr <= ghr_nxt;
            endcase
        end
    end

`ifdef PRED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else if (fb_acc) begin
            stat_br <= stat_br + 32'd1;
            if (fb_mis) stat_mis <= stat_mis + 32'd1;
        end
    end
`else
    assign stat_br  = '0;
    assign stat_mis = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed literals plus random traffic
// checked every cycle against a table-of-ints reference model.
module tb_gshare_predictor;

    localparam int DEPTH = 256;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] pd_pc = '0;
    logic [31:0] pd_inst = 32'h13;
    logic        pd_ena = 1'b0;
    logic        pd_tk;
    logic [31:0] pd_off;
    logic [7:0]  pd_ghr;
    logic        pd_busy;
    logic        fb_ena = 1'b0;
    logic [31:0] fb_pc = '0;
    logic        fb_tk = 1'b0;
    logic [7:0]  fb_ghr = '0;
    logic        fb_mis = 1'b0;
    logic [31:0] stat_br;
    logic [31:0] stat_mis;

    int vectors = 0;
    int miscompares = 0;

    gshare_predictor #(.CNT_W(2), .IDX_W(8), .GHR_W(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pd_pc(pd_pc), .pd_inst(pd_inst), .pd_ena(pd_ena),
        .pd_tk(pd_tk), .pd_off(pd_off), .pd_ghr(pd_ghr),
        .pd_busy(pd_busy),
        .fb_ena(fb_ena), .fb_pc(fb_pc), .fb_tk(fb_tk),
        .fb_ghr(fb_ghr), .fb_mis(fb_mis),
        .stat_br(stat_br), .stat_mis(stat_mis)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_cnt [DEPTH];
    int          m_init_left = DEPTH;
    int          m_ghr = 0;
    int unsigned m_br = 0;
    int unsigned m_mis = 0;
    bit          u_tk;
    logic [31:0] u_off;
    int          u_g;
    int          u_i;
    bit          e_tk;
    logic [31:0] e_off;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] pc, input int h);
        return (int'(pc >> 2) ^ h) % DEPTH;
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        int v;
        v = (i[31] ? -4096 : 0) + (i[7] ? 2048 : 0)
            + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
        return v;
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        int v;
        v = (i[31] ? -(1 << 20) : 0) + (int'(i[19:12]) << 12)
            + (i[20] ? 2048 : 0) + (int'(i[30:21]) << 1);
        return v;
    endfunction

    function automatic void model_pred(output bit tk, output logic [31:0] off);
        tk  = 1'b0;
        off = 32'd4;
        if (pd_inst[6:0] == 7'h63) begin
            tk  = (m_init_left == 0) && (m_cnt[idx(pd_pc, m_ghr)] >= 2);
            off = imm_b(pd_inst);
        end else if (pd_inst[6:0] == 7'h6f) begin
            tk  = 1'b1;
            off = imm_j(pd_inst);
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_init_left = DEPTH;
            m_ghr = 0;
            m_br = 0;
            m_mis = 0;
        end else if (rdy) begin
            if (m_init_left > 0) begin
                m_cnt[DEPTH - m_init_left] = 1;
                m_init_left--;
            end else begin
                model_pred(u_tk, u_off);
                u_g = m_ghr;
                if (pd_ena && pd_inst[6:0] == 7'h63)
                    u_g = (m_ghr * 2 + int'(u_tk)) % 256;
                if (fb_ena) begin
                    u_i = idx(fb_pc, int'(fb_ghr));
                    if (fb_tk) m_cnt[u_i] = (m_cnt[u_i] < CMAX) ? m_cnt[u_i] + 1 : CMAX;
                    else m_cnt[u_i] = (m_cnt[u_i] > 0) ? m_cnt[u_i] - 1 : 0;
                    m_br++;
                    if (fb_mis) begin
                        m_mis++;
                        u_g = (int'(fb_ghr) * 2 + int'(fb_tk)) % 256;
                    end
                end
                m_ghr = u_g;
            end
        end
    end

    always @(negedge clk) begin
        model_pred(e_tk, e_off);
        check("pd_tk", pd_tk, e_tk);
        check("pd_off", pd_off, e_off);
        check("pd_ghr", pd_ghr, m_ghr);
        check("pd_busy", pd_busy, m_init_left > 0);
`ifdef PRED_STATS_EN
        check("stat_br", stat_br, m_br);
        check("stat_mis", stat_mis, m_mis);
`else
        check("stat_br", stat_br, 0);
        check("stat_mis", stat_mis, 0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fb(input logic [31:0] pc, input logic [7:0] g,
                      input logic tk, input logic mis);
        fb_pc = pc;
        fb_ghr = g;
        fb_tk = tk;
        fb_mis = mis;
        fb_ena = 1'b1;
        tick();
        fb_ena = 1'b0;
        fb_mis = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        // Init sweep with feedback that must be ignored
        pd_inst = 32'h63;
        pd_pc = 32'h100;
        fb_ena = 1'b1;
        fb_tk = 1'b1;
        fb_pc = 32'h100;
        fb_ghr = '0;
        for (int i = 0; i < 256; i++) begin
            #1;
            check("t1_busy", pd_busy, 1);
            check("t1_tk", pd_tk, 0);
            tick();
        end
        fb_ena = 1'b0;
        #1;
        check("t1_done", pd_busy, 0);
        check("t2_tk", pd_tk, 0);
        check("t1_off", pd_off, 0);

        // Training on pc 0x100, ghr 0
        fb(32'h100, 8'h00, 1'b1, 1'b0);
        #1 check("t3_one", pd_tk, 1);
        repeat (3) fb(32'h100, 8'h00, 1'b1, 1'b0);
        fb(32'h100, 8'h00, 1'b0, 1'b0);
        #1 check("t3_cnt2", pd_tk, 1);
        fb(32'h100, 8'h00, 1'b0, 1'b0);
        #1 check("t3_cnt1", pd_tk, 0);

        pd_inst = 32'h0080006f;
        #1 check("t4_jal_tk", pd_tk, 1);
        check("t4_jal_off", pd_off, 32'h8);
        pd_inst = 32'hfe000ee3;
        #1 check("t4_beq_off", pd_off, 32'hfffffffc);
        pd_inst = 32'h00000013;
        #1 check("t4_addi_tk", pd_tk, 0);
        check("t4_addi_off", pd_off, 32'h4);

        // Speculation: NT, NT, T
        fb(32'h200, 8'h00, 1'b1, 1'b0);
        pd_inst = 32'h63;
        pd_ena = 1'b1;
        pd_pc = 32'h100;
        #1 check("t5_p0", pd_tk, 0);
        tick();
        #1 check("t5_p1", pd_tk, 0);
        tick();
        pd_pc = 32'h200;
        #1 check("t5_p2", pd_tk, 1);
        tick();
        pd_ena = 1'b0;
        #1 check("t5_spec", pd_ghr, 8'h01);
        pd_ena = 1'b1;
        fb_ena = 1'b1;
        fb_mis = 1'b1;
        fb_ghr = 8'h05;
        fb_tk = 1'b0;
        fb_pc = 32'h300;
        tick();
        pd_ena = 1'b0;
        fb_ena = 1'b0;
        fb_mis = 1'b0;
        #1 check("t5_recover", pd_ghr, 8'h0a);
        rdy = 1'b0;
        fb_ena = 1'b1;
        fb_mis = 1'b1;
        fb_tk = 1'b1;
        fb_ghr = 8'h03;
        pd_ena = 1'b1;
        repeat (3) begin
            tick();
            #1 check("t5_freeze", pd_ghr, 8'h0a);
        end
        rdy = 1'b1;
        fb_ena = 1'b0;
        fb_mis = 1'b0;
        pd_ena = 1'b0;

        // Reset mid-RUN, then stats
        rst = 1'b0;
        #1 check("t6_rbusy", pd_busy, 1);
        check("t6_rbr", stat_br, 0);
        check("t6_rmis", stat_mis, 0);
        check("t6_rghr", pd_ghr, 0);
        tick();
        rst = 1'b1;
        repeat (256) tick();
        #1 check("t6_run", pd_busy, 0);
        for (int i = 0; i < 10; i++)
            fb(32'h40 * i, 8'(i), i[0], i < 3);
        #1;
`ifdef PRED_STATS_EN
        check("t6_br", stat_br, 10);
        check("t6_mis", stat_mis, 3);
`else
        check("t6_br", stat_br, 0);
        check("t6_mis", stat_mis, 0);
`endif

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom % 8) != 0;
            rst = !(c >= 2000 && c < 2003);
            pd_pc = ($urandom & 32'hffff_f000) | (32'($urandom_range(0, 7)) << 2);
            r = $urandom;
            case ($urandom % 3)
                0: r[6:0] = 7'h63;
                1: r[6:0] = 7'h6f;
                default: if (r[6:0] == 7'h63 || r[6:0] == 7'h6f) r[6:0] = 7'h13;
            endcase
            pd_inst = r;
            pd_ena = $urandom % 2;
            fb_ena = ($urandom % 3) == 0;
            fb_pc = ($urandom & 32'hffff_f000) | (32'($urandom_range(0, 7)) << 2);
            fb_ghr = 8'($urandom_range(0, 3));
            fb_tk = $urandom % 2;
            fb_mis = ($urandom % 4) == 0;
            tick();
        end
        rst = 1'b1;
        rdy = 1'b1;
        fb_ena = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
